apb_ram_param: RTL and testbench

APB_RAM_PARAM -- requirements
Module: apb_ram_param

---
 rtl/apb_ram_param.sv | 199 +++++++++++++++++++
 tb/tb_apb_ram_param.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_ram_param.sv
// apb_ram_param: parameterised APB slave RAM with optional wait states.
//
// Parameters:
//   DATA_W      data width in bits (multiple of 8, 8..64)
//   DEPTH       number of words (2..4096)
//   WAIT_CYCLES wait states inserted per transfer (0..15)
//
// Ports:
//   pclk     clock, rising edge
//   preset   asynchronous active-high reset
//   psel     slave select
//   penable  access-phase indicator
//   pwrite   1 = write, 0 = read
//   paddr    byte address
//   pwdata   write data
//   pstrb    byte write strobes
//   prdata   read data (registered)
//   pready   transfer complete (registered)
//   pslverr  transfer error (registered, valid while pready=1)
//
// Build option:
//   APB_RAM_STRB_EN  when defined, writes update only the bytes whose pstrb
//                    bit is set; when undefined, writes update the full word
//                    and pstrb is ignored.
module apb_ram_param #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [31:0]           paddr,
    input  logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W/8-1:0]   pstrb,
    output logic [DATA_W-1:0]     prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS
    } state_t;

    // Transfer captured during the setup phase
    typedef struct packed {
        logic [AW-1:0]     idx;
        logic              write;
        logic              err;
        logic [DATA_W-1:0] wdata;
`ifdef APB_RAM_STRB_EN
        logic [BYTES-1:0]  strb;
`endif
    } req_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    req_t              req, req_n;
    req_t              cur_req;
    req_t              acc_req;
    logic              pready_n;
    logic              pslverr_n;
    logic [DATA_W-1:0] prdata_n;
    logic              mem_we;
    logic              enter;
    logic [31:0]       word_idx;
    logic              addr_err;

    logic [DATA_W-1:0] mem [DEPTH];

`ifndef APB_RAM_STRB_EN
    // Strobes have no effect in the full-word build
    logic unused_strb;
    assign unused_strb = ^pstrb;
`endif

    // Decode of the live bus address
    assign word_idx = paddr >> OFF_W;
    assign addr_err = (word_idx >= 32'(DEPTH)) ||
                      ((paddr & 32'(BYTES - 1)) != 32'd0);

    always_comb begin
        cur_req       = '0;
        cur_req.idx   = AW'(word_idx);
        cur_req.write = pwrite;
        cur_req.err   = addr_err;
        cur_req.wdata = pwdata;
`ifdef APB_RAM_STRB_EN
        cur_req.strb  = pstrb;
`endif
    end

    // With no wait states ACCESS is entered straight from the setup edge,
    // so the live bus is used; otherwise the captured request is used.
    assign acc_req = (state == IDLE) ? cur_req : req;

    // State register and registered outputs
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state   <= IDLE;
            cnt     <= '0;
            req     <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            req     <= req_n;
            pready  <= pready_n;
            pslverr <= pslverr_n;
            prdata  <= prdata_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        req_n     = req;
        pready_n  = pready;
        pslverr_n = pslverr;
        prdata_n  = prdata;
        mem_we    = 1'b0;
        enter     = 1'b0;

        unique case (state)
            IDLE: begin
                if (psel && !penable) begin
                    req_n = cur_req;
                    if (WAIT_CYCLES == 0) begin
                        state_n = ACCESS;
                        enter   = 1'b1;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = CW'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                if (psel && penable) begin
                    if (cnt <= CW'(1)) begin
                        state_n = ACCESS;
                        cnt_n   = '0;
                        enter   = 1'b1;
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            ACCESS: begin
                // Completion commits the write; an abort simply drops it
                mem_we    = psel && penable && pready && req.write && !req.err;
                state_n   = IDLE;
                pready_n  = 1'b0;
                pslverr_n = 1'b0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (enter) begin
            pready_n  = 1'b1;
            pslverr_n = acc_req.err;
            if (!acc_req.write) begin
                prdata_n = acc_req.err ? '0 : mem[acc_req.idx];
            end
        end
    end

    // Storage; not cleared by reset
    always_ff @(posedge pclk) begin
        if (mem_we) begin
`ifdef APB_RAM_STRB_EN
            for (int b = 0; b < int'(BYTES); b++) begin
                if (req.strb[b]) begin
                    mem[req.idx][b*8 +: 8] <= req.wdata[b*8 +: 8];
                end
            end
`else
            mem[req.idx] <= req.wdata;
`endif
        end
    end

endmodule

// File: tb/tb_apb_ram_param.sv
// Bench for apb_ram_param: three configurations sharing one APB bus, each
// with its own psel, checked against an array-based memory model.
module tb_apb_ram_param;

    logic        pclk;
    logic        preset;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [63:0] pwdata;
    logic [7:0]  pstrb;
    logic [31:0] prdata0, prdata1;
    logic [63:0] prdata2;
    logic        pready0, pready1, pready2;
    logic        pslverr0, pslverr1, pslverr2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] mdl     [3][32];
    logic [63:0] last_rd [3];

    apb_ram_param u0 (
        .pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata[31:0]), .pstrb(pstrb[3:0]),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    apb_ram_param #(.DATA_W(32), .DEPTH(20), .WAIT_CYCLES(2)) u1 (
        .pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata[31:0]), .pstrb(pstrb[3:0]),
        .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
    );

    apb_ram_param #(.DATA_W(64), .DEPTH(8), .WAIT_CYCLES(3)) u2 (
        .pclk(pclk), .preset(preset), .psel(psel[2]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata2), .pready(pready2), .pslverr(pslverr2)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int dw(input int d);
        return (d == 2) ? 64 : 32;
    endfunction

    function automatic int dep(input int d);
        case (d)
            0:       return 32;
            1:       return 20;
            default: return 8;
        endcase
    endfunction

    function automatic int wt(input int d);
        case (d)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic rdy(input int d);
        case (d)
            0:       return pready0;
            1:       return pready1;
            default: return pready2;
        endcase
    endfunction

    function automatic logic serr(input int d);
        case (d)
            0:       return pslverr0;
            1:       return pslverr1;
            default: return pslverr2;
        endcase
    endfunction

    function automatic logic [63:0] get_rd(input int d);
        case (d)
            0:       return {32'h0, prdata0};
            1:       return {32'h0, prdata1};
            default: return prdata2;
        endcase
    endfunction

    function automatic logic is_err(input int d, input logic [31:0] a);
        logic [31:0] bytes;
        bytes = 32'(dw(d) / 8);
        return ((a / bytes) >= 32'(dep(d))) || ((a % bytes) != 32'd0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model of a committed write
    task automatic mdl_write(input int d, input logic [31:0] a,
                             input logic [63:0] wd, input logic [7:0] st);
        int i;
        int bytes;
        logic [63:0] w;
        bytes = dw(d) / 8;
        i     = int'(a) / bytes;
        w     = mdl[d][i];
`ifdef APB_RAM_STRB_EN
        for (int b = 0; b < bytes; b++) begin
            if (st[b]) w[b*8 +: 8] = wd[b*8 +: 8];
        end
`else
        w = wd;
        if (st == 8'hxx) w = 64'h0;
`endif
        if (dw(d) == 32) w[63:32] = 32'h0;
        mdl[d][i] = w;
    endtask

    // One complete transfer; leaves the bus idle so a following call is back-to-back
    task automatic xfer(input int d, input logic [31:0] a, input logic w,
                        input logic [63:0] wd, input logic [7:0] st,
                        output logic [63:0] rd);
        logic        exp_err;
        logic [63:0] exp_rd;
        int          n;
        exp_err = is_err(d, a);
        psel    = 3'(1 << d);
        penable = 1'b0;
        paddr   = a;
        pwrite  = w;
        pwdata  = wd;
        pstrb   = st;
        @(posedge pclk); #1;
        penable = 1'b1;
        n = 1;
        while (!rdy(d) && n < 40) begin
            @(posedge pclk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(1 + wt(d)));
        chk("pslverr", 64'(serr(d)), 64'(exp_err));
        if (!w) begin
            exp_rd     = exp_err ? 64'h0 : mdl[d][int'(a) / (dw(d) / 8)];
            last_rd[d] = exp_rd;
            chk("read_data", get_rd(d), exp_rd);
        end else begin
            chk("prdata_hold", get_rd(d), last_rd[d]);
            if (!exp_err) mdl_write(d, a, wd, st);
        end
        rd = get_rd(d);
        @(posedge pclk); #1;
        chk("pready_clear", 64'(rdy(d)), 64'h0);
        psel    = 3'b000;
        penable = 1'b0;
    endtask

    // Write transfer dropped after 'hold' access cycles
    task automatic abort_wr(input int d, input logic [31:0] a,
                            input logic [63:0] wd, input int hold);
        psel    = 3'(1 << d);
        penable = 1'b0;
        paddr   = a;
        pwrite  = 1'b1;
        pwdata  = wd;
        pstrb   = 8'hFF;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (hold) begin
            @(posedge pclk); #1;
        end
        psel    = 3'b000;
        penable = 1'b0;
        @(posedge pclk); #1;
        chk("abort_pready", 64'(rdy(d)), 64'h0);
        chk("abort_pslverr", 64'(serr(d)), 64'h0);
    endtask

    initial begin
        logic [63:0] rd;
        logic [31:0] a;
        int          d;
        int          r;
        int          bytes;

        preset  = 1'b1;
        psel    = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0;
        pwdata  = 64'h0;
        pstrb   = 8'h0;
        for (int k = 0; k < 3; k++) last_rd[k] = 64'h0;

        repeat (3) @(posedge pclk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_pready", 64'(rdy(k)), 64'h0);
            chk("reset_pslverr", 64'(serr(k)), 64'h0);
            chk("reset_prdata", get_rd(k), 64'h0);
        end
        preset = 1'b0;

        // Give every word a known value
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < dep(k); i++) begin
                xfer(k, 32'(i * (dw(k) / 8)), 1'b1, {$urandom, $urandom}, 8'hFF, rd);
            end
        end

        // Basic write / read back at default configuration
        xfer(0, 32'h0C, 1'b1, 64'hDEADBEEF, 8'hFF, rd);
        xfer(0, 32'h0C, 1'b0, 64'h0, 8'h00, rd);
        chk("deadbeef", rd, 64'hDEADBEEF);

        // Out-of-range and misaligned errors leave memory untouched
        xfer(0, 32'h80, 1'b1, 64'h12345678, 8'hFF, rd);
        xfer(0, 32'h02, 1'b1, 64'h12345678, 8'hFF, rd);
        xfer(0, 32'h80, 1'b0, 64'h0, 8'hFF, rd);
        chk("err_read_zero", rd, 64'h0);
        xfer(0, 32'h7C, 1'b0, 64'h0, 8'hFF, rd);
        xfer(0, 32'h00, 1'b0, 64'h0, 8'hFF, rd);

        // Byte strobes
        xfer(0, 32'h04, 1'b1, 64'h11223344, 8'hFF, rd);
        xfer(0, 32'h04, 1'b1, 64'hAABBCCDD, 8'h05, rd);
        xfer(0, 32'h04, 1'b0, 64'h0, 8'h00, rd);
`ifdef APB_RAM_STRB_EN
        chk("strobe_merge", rd, 64'h11BB33DD);
`else
        chk("strobe_merge", rd, 64'hAABBCCDD);
`endif

        // Wait states and 64-bit words
        xfer(2, 32'h00, 1'b0, 64'h0, 8'h00, rd);
        xfer(2, 32'h38, 1'b1, 64'h0123456789ABCDEF, 8'hFF, rd);
        xfer(2, 32'h38, 1'b0, 64'h0, 8'h00, rd);
        chk("wide_data", rd, 64'h0123456789ABCDEF);
        xfer(2, 32'h40, 1'b1, 64'h1, 8'hFF, rd);
        xfer(1, 32'h4C, 1'b0, 64'h0, 8'h00, rd);
        xfer(1, 32'h50, 1'b0, 64'h0, 8'h00, rd);

        // Inputs other than a setup phase are ignored in IDLE
        psel    = 3'b001;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 32'h0C;
        repeat (2) begin
            @(posedge pclk); #1;
            chk("idle_ignore", 64'(pready0), 64'h0);
        end
        psel    = 3'b000;
        penable = 1'b0;
        xfer(0, 32'h0C, 1'b0, 64'h0, 8'h00, rd);
        chk("idle_nowrite", rd, 64'hDEADBEEF);

        // Protocol aborts drop the write
        abort_wr(0, 32'h80, 64'h55, 0);
        abort_wr(0, 32'h10, 64'hCAFEF00D, 0);
        abort_wr(2, 32'h10, 64'hCAFEF00D_CAFEF00D, 1);
        abort_wr(1, 32'h10, 64'hCAFEF00D, 1);
        xfer(0, 32'h10, 1'b0, 64'h0, 8'h00, rd);
        xfer(2, 32'h10, 1'b0, 64'h0, 8'h00, rd);
        xfer(1, 32'h10, 1'b0, 64'h0, 8'h00, rd);

        // Asynchronous reset during the wait phase of a write
        xfer(1, 32'h08, 1'b1, 64'h5A5A0001, 8'hFF, rd);
        xfer(1, 32'h08, 1'b0, 64'h0, 8'h00, rd);
        psel    = 3'b010;
        penable = 1'b0;
        paddr   = 32'h08;
        pwrite  = 1'b1;
        pwdata  = 64'h0BADF00D;
        pstrb   = 8'hFF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        chk("rst_wait_pready", 64'(pready1), 64'h0);
        #2;
        preset = 1'b1;
        #1;
        chk("rst_async_prdata", get_rd(1), 64'h0);
        chk("rst_async_pready", 64'(pready1), 64'h0);
        chk("rst_async_pslverr", 64'(pslverr1), 64'h0);
        for (int k = 0; k < 3; k++) last_rd[k] = 64'h0;
        #2;
        preset  = 1'b0;
        psel    = 3'b000;
        penable = 1'b0;
        @(posedge pclk); #1;
        xfer(1, 32'h08, 1'b0, 64'h0, 8'h00, rd);
        chk("rst_nowrite", rd, 64'h5A5A0001);

        // Randomised traffic, mostly back-to-back
        for (int t = 0; t < 400; t++) begin
            d     = $urandom_range(0, 2);
            bytes = dw(d) / 8;
            r     = $urandom_range(0, 9);
            if (r < 7)
                a = 32'($urandom_range(0, dep(d) - 1) * bytes);
            else if (r == 7)
                a = 32'((dep(d) + $urandom_range(0, 3)) * bytes);
            else if (r == 8)
                a = 32'($urandom_range(0, dep(d) - 1) * bytes + $urandom_range(1, bytes - 1));
            else
                a = $urandom | 32'h8000_0000;
            xfer(d, a, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                 8'($urandom), rd);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge pclk); #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
